// File: rtl/adc_capture_gate.sv
// adc_capture_gate
//   Trigger-gated capture front end feeding the S2MM DMA writer. Takes the
//   free-running ADC beat stream, waits for arm plus a trigger edge, then
//   forwards cap_size bytes (16 bytes per beat) through a small FWFT FIFO
//   onto an AXI4-Stream master.
//
// Ports
//   axi_aclk, axi_rst       clock, synchronous active-high reset
//   s_adc_tdata/tvalid      ADC beat stream, no backpressure
//   trig_in                 external trigger level (rising edge used)
//   sw_trig                 software trigger pulse
//   arm, abort              control pulses
//   cap_size                capture length in bytes, latched on arm
//   m_axis_tdata/tvalid/tready  stream to the DMA writer
//   busy, done              status (ARMED/CAPTURE/DRAIN, DONE)
//   overflow                sticky: a beat was dropped on a full FIFO
//   beat_count              ADC beats consumed in the current capture
//
// State table
//   state      | meaning
//   ST_IDLE    | waiting for arm
//   ST_ARMED   | length latched, waiting for trigger edge
//   ST_CAPTURE | consuming ADC beats until len reached
//   ST_DRAIN   | all beats consumed, emptying the FIFO
//   ST_DONE    | capture complete, waiting for re-arm
module adc_capture_gate #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 128
) (
  input  logic              axi_aclk,
  input  logic              axi_rst,
  input  logic [DATA_W-1:0] s_adc_tdata,
  input  logic              s_adc_tvalid,
  input  logic              trig_in,
  input  logic              sw_trig,
  input  logic              arm,
  input  logic              abort,
  input  logic [31:0]       cap_size,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [27:0]       beat_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic              trig_d;
  logic              trig_edge;
  logic [27:0]       cap_len;
  logic [27:0]       len_q;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fill;
  logic              fifo_empty, fifo_full;
  logic              fifo_rd, fifo_wr;
  logic              beat_take, beat_drop;
  logic              arm_ok;
  logic              unused_low_bits;

  // Sub-beat byte count is meaningless for 16-byte beats.
  assign unused_low_bits = ^cap_size[3:0];

  assign cap_len    = cap_size[31:4];
  assign trig_edge  = (trig_in & ~trig_d) | sw_trig;

  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == CW'(FIFO_DEPTH));
  assign fifo_rd    = ~fifo_empty & m_axis_tready;

  // In ARMED the trigger-edge beat itself is the first captured beat.
  assign beat_take  = s_adc_tvalid & ~abort &
                      ((state == ST_CAPTURE) | ((state == ST_ARMED) & trig_edge));
  // A write into a full FIFO is fine when a read frees the slot this cycle.
  assign fifo_wr    = beat_take & (~fifo_full | fifo_rd);
  assign beat_drop  = beat_take & fifo_full & ~fifo_rd;

  assign arm_ok     = arm & ~abort & ((state == ST_IDLE) | (state == ST_DONE));

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : mem[rd_ptr];
  assign busy          = (state == ST_ARMED) | (state == ST_CAPTURE) | (state == ST_DRAIN);
  assign done          = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (arm) state_nxt = (cap_len == '0) ? ST_DONE : ST_ARMED;
      end
      ST_ARMED: begin
        if (trig_edge) state_nxt = (beat_take && (len_q == 28'd1)) ? ST_DRAIN : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (beat_take && ((beat_count + 28'd1) == len_q)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave as soon as the final entry is being read out.
        if (fifo_empty || ((fill == CW'(1)) && fifo_rd)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_rst) begin
      state      <= ST_IDLE;
      trig_d     <= 1'b0;
      len_q      <= '0;
      beat_count <= '0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
    end else begin
      state  <= state_nxt;
      trig_d <= trig_in;
      if (abort) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fill       <= '0;
        beat_count <= '0;
      end else begin
        if (arm_ok) begin
          len_q      <= cap_len;
          beat_count <= '0;
          overflow   <= 1'b0;
        end else begin
          // FSM leaves CAPTURE on the len-th beat, so this never passes len.
          if (beat_take) beat_count <= beat_count + 28'd1;
          if (beat_drop) overflow   <= 1'b1;
        end
        if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
        if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
        case ({fifo_wr, fifo_rd})
          2'b10:   fill <= fill + CW'(1);
          2'b01:   fill <= fill - CW'(1);
          default: fill <= fill;
        endcase
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (fifo_wr) mem[wr_ptr] <= s_adc_tdata;
  end

endmodule
